ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter; the counterpart of the keyboard receive path. Sends one command

---
 rtl/ps2_host_tx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, raises a request-to-send and
// shifts one command byte (LSB first, odd parity) out on device-generated clock falls.
module ps2_host_tx #(
   parameter int CLK_HZ         = 100_000_000,
   parameter int INHIBIT_CYCLES = 10_000,
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int FW     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int IW     = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
   localparam int TW_MIN = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TW     = (TW_MIN > 21) ? TW_MIN : 21;

   if (CLK_HZ < 1 || FILTER_LEN < 1 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("ps2_host_tx: parameters must be positive");
   end

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      ACK,
      WAIT_IDLE
   } state_t;

   state_t state_q, state_d;

   logic [1:0]    clk_sync, data_sync;
   logic [FW-1:0] clk_fcnt, data_fcnt;
   logic          clk_filt, data_filt, clk_filt_prev;
   logic          fall;

   logic [7:0]    shreg;
   logic          par;
   logic [3:0]    bitcnt, bitcnt_d;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] to_cnt;
   logic          armed;
   logic          timeout;
   logic          cap;
   logic          clk_oe_d, data_oe_d, done_d, err_d;

   // A level change is accepted only after FILTER_LEN consecutive samples disagree
   // with the current filtered level; shorter pulses are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync      <= 2'b11;
         data_sync     <= 2'b11;
         clk_fcnt      <= '0;
         data_fcnt     <= '0;
         clk_filt      <= 1'b1;
         data_filt     <= 1'b1;
         clk_filt_prev <= 1'b1;
      end else begin
         clk_sync      <= {clk_sync[0], ps2_clk_in};
         data_sync     <= {data_sync[0], ps2_data_in};
         clk_filt_prev <= clk_filt;

         if (clk_sync[1] == clk_filt) begin
            clk_fcnt <= '0;
         end else if (clk_fcnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            clk_fcnt <= '0;
         end else begin
            clk_fcnt <= clk_fcnt + 1'b1;
         end

         if (data_sync[1] == data_filt) begin
            data_fcnt <= '0;
         end else if (data_fcnt == FW'(FILTER_LEN - 1)) begin
            data_filt <= data_sync[1];
            data_fcnt <= '0;
         end else begin
            data_fcnt <= data_fcnt + 1'b1;
         end
      end
   end

   assign fall    = clk_filt_prev & ~clk_filt;
   assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Handshake: a byte is taken on any cycle where tx_valid and tx_ready are both
   // high; tx_ready is high exactly while IDLE and tx_valid is ignored otherwise.
   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt;
      cap       = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = ps2_data_oe;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            data_oe_d = 1'b0;
            if (tx_valid) begin
               cap       = 1'b1;
               bitcnt_d  = 4'd0;
               state_d   = INHIBIT;
               clk_oe_d  = 1'b1;
               data_oe_d = (INHIBIT_CYCLES == 1);
            end
         end

         INHIBIT: begin
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
               state_d   = REQ;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
            end else begin
               clk_oe_d  = 1'b1;
               data_oe_d = (inh_cnt == IW'(INHIBIT_CYCLES - 2));
            end
         end

         REQ: begin
            if (timeout) begin
               state_d   = IDLE;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
            end else if (fall && armed) begin
               bitcnt_d = bitcnt + 4'd1;
               if (bitcnt == 4'd9) begin
                  data_oe_d = 1'b0;
                  state_d   = ACK;
               end else if (bitcnt == 4'd8) begin
                  data_oe_d = ~par;
               end else begin
                  data_oe_d = ~shreg[bitcnt[2:0]];
               end
            end
         end

         ACK: begin
            data_oe_d = 1'b0;
            if (timeout) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (fall) begin
               if (data_filt) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end else begin
                  state_d = WAIT_IDLE;
               end
            end
         end

         WAIT_IDLE: begin
            data_oe_d = 1'b0;
            if (timeout) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (clk_filt && data_filt) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d   = IDLE;
            data_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tx_ready    <= 1'b1;
         busy        <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         shreg       <= '0;
         par         <= 1'b0;
         bitcnt      <= '0;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         armed       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_ready    <= (state_d == IDLE);
         busy        <= (state_d != IDLE);
         ps2_clk_oe  <= clk_oe_d;
         ps2_data_oe <= data_oe_d;
         tx_done     <= done_d;
         tx_err      <= err_d;
         bitcnt      <= bitcnt_d;
         if (cap) begin
            shreg <= tx_data;
            par   <= ~^tx_data;
         end
         inh_cnt <= (state_q == INHIBIT) ? inh_cnt + 1'b1 : '0;
         to_cnt  <= (state_q == REQ || state_q == ACK || state_q == WAIT_IDLE) ? to_cnt + 1'b1 : '0;
         // Falls only count once the released clock has been seen high in REQ,
         // so the edge caused by our own inhibit can never shift a bit.
         armed   <= (state_q == REQ) && (armed || clk_filt);
      end
   end

endmodule
